// File: rtl/sfx_pkg.sv
// sfx_pkg: effect ids, segment record, effect table and priority order shared by the sfx blocks
package sfx_pkg;
  localparam int HALF_W = 18;
  localparam int LEN_W = 25;
  typedef enum logic [2:0] {
    EFF_NONE   = 3'd0,
    EFF_FRUIT  = 3'd1,
    EFF_BOMB   = 3'd2,
    EFF_LIFE   = 3'd3,
    EFF_JINGLE = 3'd4
  } eff_e;
  typedef struct packed {
    logic              silent;
    logic [HALF_W-1:0] half;
    logic [LEN_W-1:0]  len;
  } seg_t;
  localparam seg_t SEG_NONE  = '{1'b1, 18'd0, 25'd0};
  localparam seg_t SEG_FRUIT = '{1'b0, 18'd30000, 25'd6500000};
  localparam seg_t SEG_BOMB  = '{1'b0, 18'd150000, 25'd30000000};
  localparam seg_t SEG_LIFE  = '{1'b0, 18'd150000, 25'd6500000};
  localparam seg_t SEG_JGAP  = '{1'b1, 18'd0, 25'd30000000};
  localparam seg_t SEG_JHI   = '{1'b0, 18'd110670, 25'd15000000};
  localparam seg_t SEG_JLO   = '{1'b0, 18'd82909, 25'd30000000};
  function automatic seg_t seg_of(eff_e e, logic [1:0] s);
    return e == EFF_FRUIT ? SEG_FRUIT :
           e == EFF_BOMB  ? SEG_BOMB  :
           e == EFF_LIFE  ? SEG_LIFE  :
           e != EFF_JINGLE ? SEG_NONE :
           s == 2'd0 ? SEG_JGAP : s == 2'd1 ? SEG_JHI : SEG_JLO;
  endfunction
  function automatic logic [1:0] last_seg(eff_e e);
    return e == EFF_JINGLE ? 2'd2 : 2'd0;
  endfunction
  // pending bit i belongs to effect id i+1
  function automatic logic [3:0] eff_bit(eff_e e);
    return e == EFF_NONE ? 4'd0 : 4'd1 << (e - 3'd1);
  endfunction
  function automatic eff_e pick(logic [3:0] p);
    return p[1] ? EFF_BOMB : p[2] ? EFF_LIFE : p[3] ? EFF_JINGLE : p[0] ? EFF_FRUIT : EFF_NONE;
  endfunction
  function automatic logic [2:0] rank(eff_e e);
    return e == EFF_BOMB ? 3'd4 : e == EFF_LIFE ? 3'd3 : e == EFF_JINGLE ? 3'd2 :
           e == EFF_FRUIT ? 3'd1 : 3'd0;
  endfunction
endpackage

// File: rtl/sfx_tone.sv
// sfx_tone: square-wave generator toggling every half+1 cycles, gated low by silent and mute
module sfx_tone
  import sfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [HALF_W-1:0] half,
  input  logic              silent,
  input  logic              mute,
  output logic              wave
);
  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              sq_q, sq_d;
  always_comb begin
    cnt_d = (load || cnt_q == half) ? '0 : cnt_q + 1'b1;
    sq_d  = load ? 1'b0 : sq_q ^ (cnt_q == half);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end
  assign wave = sq_q & ~silent & ~mute;
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: latches sound-effect request edges, grants by fixed priority, sequences tone segments.
// Define SFX_PREEMPT_EN to let a strictly higher-priority pending request abort the playing effect.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int SCALE_SHIFT = 0
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_fruit,
  input  logic       req_bomb,
  input  logic       req_life,
  input  logic       req_jingle,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic [2:0] active_id,
  output logic       dropped
);
  typedef enum logic {IDLE, PLAY} state_e;
  state_e            state_q, state_d;
  eff_e              eff_q, eff_d, best;
  logic [1:0]        seg_q, seg_d;
  logic [LEN_W-1:0]  dur_q, dur_d, len;
  logic [HALF_W-1:0] half;
  logic [3:0]        req, in_q, prev_q, edges, pend_q, pend_d, gmask;
  logic              dropped_q, dropped_d, grant, preempt, load, seg_end;
  seg_t              seg;
  assign req   = {req_jingle, req_life, req_bomb, req_fruit};
  assign edges = in_q & ~prev_q;
  always_comb begin
    best    = pick(pend_q);
    seg     = seg_of(eff_q, seg_q);
    len     = seg.len >> SCALE_SHIFT;
    half    = seg.half >> SCALE_SHIFT;
    seg_end = dur_q == len;
`ifdef SFX_PREEMPT_EN
    preempt = state_q == PLAY && rank(best) > rank(eff_q);
`else
    preempt = 1'b0;
`endif
    grant     = (state_q == IDLE && best != EFF_NONE) || preempt;
    gmask     = grant ? eff_bit(best) : 4'd0;
    pend_d    = (pend_q & ~gmask) | edges;
    dropped_d = |(edges & pend_q & ~gmask);
    state_d   = state_q;
    eff_d     = eff_q;
    seg_d     = seg_q;
    dur_d     = dur_q + 1'b1;
    load      = 1'b0;
    if (grant) begin
      state_d = PLAY;
      eff_d   = best;
      seg_d   = '0;
      dur_d   = '0;
      load    = 1'b1;
    end else if (state_q == IDLE) begin
      dur_d = '0;
    end else if (seg_end && seg_q == last_seg(eff_q)) begin
      state_d = IDLE;
      eff_d   = EFF_NONE;
      seg_d   = '0;
      dur_d   = '0;
    end else if (seg_end) begin
      seg_d = seg_q + 2'd1;
      dur_d = '0;
      load  = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      eff_q     <= EFF_NONE;
      seg_q     <= '0;
      dur_q     <= '0;
      in_q      <= '1;
      prev_q    <= '1;
      pend_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      eff_q     <= eff_d;
      seg_q     <= seg_d;
      dur_q     <= dur_d;
      in_q      <= req;
      prev_q    <= in_q;
      pend_q    <= pend_d;
      dropped_q <= dropped_d;
    end
  end
  sfx_tone u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .half   (half),
    .silent (state_q != PLAY || seg.silent),
    .mute   (mute),
    .wave   (sound)
  );
  assign busy      = state_q == PLAY;
  assign active_id = eff_q;
  assign dropped   = dropped_q;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: scoreboard bench for sfx_scheduler at SCALE_SHIFT 12 to keep the run short.
// Expected per effect: id, busy cycles (len>>12)+1 per segment, first toggle and toggle spacing (half>>12)+1.
module tb_sfx_scheduler;
  localparam int SH = 12;
  typedef struct {
    int id;
    int dur;
    int first;
    int intv;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_fruit = 1'b0, req_bomb = 1'b0, req_life = 1'b0, req_jingle = 1'b0, mute = 1'b0;
  logic       sound, busy, dropped;
  logic [2:0] active_id;
  int         checks = 0, errors = 0, drops = 0;
  bit         in_eff = 1'b0;
  exp_t       q[$];

  sfx_scheduler #(.SCALE_SHIFT(SH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_fruit  (req_fruit),
    .req_bomb   (req_bomb),
    .req_life   (req_life),
    .req_jingle (req_jingle),
    .mute       (mute),
    .sound      (sound),
    .busy       (busy),
    .active_id  (active_id),
    .dropped    (dropped)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int id, input int dur, input int first, input int intv);
    exp_t e;
    e.id = id;
    e.dur = dur;
    e.first = first;
    e.intv = intv;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic v, input int lim, input string name);
    int n = 0;
    while (busy !== v && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== v) begin
      errors++;
      $display("FAIL %s: busy %b after %0d cycles expected %b", name, busy, n, v);
    end
  endtask

  initial begin : monitor
    int   cur, idx, first, intv, lastt;
    logic psnd;
    exp_t e;
    cur = 0; idx = 0; first = -1; intv = -1; lastt = 0; psnd = 1'b0;
    forever begin
      @(negedge clk);
      if (dropped === 1'b1) drops++;
      if (mute === 1'b1) chk("mute_sound", int'(sound), 0);
      if (rst_n !== 1'b1) begin
        in_eff = 1'b0;
      end else begin
        if (in_eff && (busy !== 1'b1 || int'(active_id) != cur)) begin
          in_eff = 1'b0;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_effect: got id %0d expected none", cur);
          end else begin
            e = q.pop_front();
            chk("eff_id", cur, e.id);
            chk("eff_dur", idx, e.dur);
            chk("eff_first_toggle", first, e.first);
            chk("eff_toggle_interval", intv, e.intv);
          end
        end
        if (busy === 1'b1 && !in_eff) begin
          in_eff = 1'b1;
          cur = int'(active_id);
          idx = 0; first = -1; intv = -1; lastt = 0; psnd = 1'b0;
        end
        if (in_eff) begin
          if (sound !== psnd) begin
            if (first < 0) first = idx;
            else intv = idx - lastt;
            lastt = idx;
            psnd = sound;
          end
          idx++;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int d0;
    req_life = 1'b1;
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sound", int'(sound), 0);
    chk("rst_id", int'(active_id), 0);
    chk("rst_dropped", int'(dropped), 0);
    rst_n = 1'b1;
    tick(5);
    chk("held_high_no_event", int'(busy), 0);
    req_life = 1'b0;
    tick(2);
    // fruit pulse from idle: grant two edges after the sampling edge
    q.push_back(mk(1, 1587, 8, 8));
    req_fruit = 1'b1;
    tick();
    chk("lat_k_busy", int'(busy), 0);
    tick();
    chk("lat_k1_busy", int'(busy), 0);
    tick();
    chk("lat_k2_busy", int'(busy), 1);
    chk("lat_k2_id", int'(active_id), 1);
    req_fruit = 1'b0;
    wait_busy(1'b0, 2000, "fruit_end");
    tick(3);
    // bomb and fruit together: bomb first, one idle cycle, then fruit
    q.push_back(mk(2, 7325, 37, 37));
    q.push_back(mk(1, 1587, 8, 8));
    req_bomb = 1'b1;
    req_fruit = 1'b1;
    tick(3);
    chk("both_first_id", int'(active_id), 2);
    req_bomb = 1'b0;
    req_fruit = 1'b0;
    wait_busy(1'b0, 9000, "both_bomb_end");
    tick();
    chk("gap_busy", int'(busy), 1);
    chk("gap_id", int'(active_id), 1);
    wait_busy(1'b0, 2000, "both_fruit_end");
    tick(3);
    // jingle: silent gap, then two tones
    q.push_back(mk(4, 18313, 7353, 21));
    req_jingle = 1'b1;
    tick(3);
    chk("jingle_id", int'(active_id), 4);
    req_jingle = 1'b0;
    wait_busy(1'b0, 20000, "jingle_end");
    tick(3);
    // two fruit edges during a bomb: second merges and pulses dropped
    q.push_back(mk(2, 7325, 37, 37));
    q.push_back(mk(1, 1587, 8, 8));
    d0 = drops;
    req_bomb = 1'b1;
    tick(3);
    req_bomb = 1'b0;
    tick(20);
    req_fruit = 1'b1;
    tick(2);
    req_fruit = 1'b0;
    tick(3);
    chk("first_edge_no_drop", drops - d0, 0);
    req_fruit = 1'b1;
    tick(2);
    req_fruit = 1'b0;
    tick(3);
    chk("second_edge_drop", drops - d0, 1);
    wait_busy(1'b0, 9000, "merge_bomb_end");
    tick();
    chk("merge_fruit_id", int'(active_id), 1);
    wait_busy(1'b0, 2000, "merge_fruit_end");
    tick(5);
    // bomb edge 100 cycles into a fruit effect
`ifdef SFX_PREEMPT_EN
    q.push_back(mk(1, 103, 8, 8));
`else
    q.push_back(mk(1, 1587, 8, 8));
`endif
    q.push_back(mk(2, 7325, 37, 37));
    req_fruit = 1'b1;
    tick(3);
    req_fruit = 1'b0;
    chk("pre_fruit_id", int'(active_id), 1);
    tick(100);
    req_bomb = 1'b1;
    tick(2);
    chk("pre_hold_id", int'(active_id), 1);
    tick();
`ifdef SFX_PREEMPT_EN
    chk("pre_switch_id", int'(active_id), 2);
    req_bomb = 1'b0;
`else
    chk("pre_switch_id", int'(active_id), 1);
    req_bomb = 1'b0;
    wait_busy(1'b0, 2000, "pre_fruit_end");
    tick();
    chk("bomb_after_fruit_id", int'(active_id), 2);
`endif
    wait_busy(1'b0, 9000, "pre_bomb_end");
    tick(3);
    // reset mid-bomb with mute toggled and a fruit pending
    req_bomb = 1'b1;
    tick(3);
    req_bomb = 1'b0;
    tick(200);
    mute = 1'b1;
    tick(80);
    mute = 1'b0;
    tick(40);
    req_fruit = 1'b1;
    tick(3);
    req_fruit = 1'b0;
    mute = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_sound", int'(sound), 0);
    chk("rst2_id", int'(active_id), 0);
    chk("rst2_dropped", int'(dropped), 0);
    tick(2);
    rst_n = 1'b1;
    mute = 1'b0;
    tick(60);
    chk("pending_lost", int'(busy), 0);
    chk("queue_empty", q.size(), 0);
    chk("no_open_effect", int'(in_eff), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
